pll_lock_sequencer: RTL and testbench
=====================================

// Module: pll_lock_sequencer
// PURPOSE
// Controller side of the core PLL interface: drives the PLL's active-high rst and consumes
// its asynchronous locked flag. Pulses PLL reset, waits for lock with timeout and bounded
// retries, requires a stable-lock window, then releases core reset. On lock loss it holds
// the core in reset and re-runs the sequence. Sits between the PLL wrapper and core reset tree.
// PARAMETERS
// RST_PULSE_CYCLES     16      cycles pll_rst is held high per reset pulse (>=1)
// LOCK_TIMEOUT_CYCLES  742500  cycles to wait for lock after pll_rst falls (10 ms @ 74.25 MHz)
// STABLE_CYCLES        4096    consecutive synced-locked cycles required before release (>=1)
// MAX_RETRIES          3       timeout retries before FAIL (0..15)
// PORTS
// clk_74a          in   1  free-running reference clock; PLL refclk domain
// reset_n          in   1  asynchronous active-low reset
// pll_locked       in   1  PLL locked flag, asynchronous to clk_74a
// relock_req       in   1  single-cycle pulse: force a full PLL re-lock sequence
// pll_rst          out  1  active-high reset to the PLL
// core_reset_n     out  1  active-low reset to the core clock domains
// pll_ready        out  1  high only in RUN
// fail             out  1  high only in FAIL (retries exhausted)
// retry_count      out  4  timeouts since last successful lock or relock_req
// lock_loss_count  out  8  lock losses while in RUN, saturates at 255
// BEHAVIOUR
// - Reset (reset_n=0, async): state=PLL_RST, pll_rst=1, core_reset_n=0, pll_ready=0, fail=0,
//   retry_count=0, lock_loss_count=0, all timers 0, sync flops 0.
// - pll_locked passes through a 2-flop synchronizer -> locked_s; only locked_s is used.
// - All outputs registered, decoded from next-state: they change on the edge the FSM enters a state.
// - PLL_RST: pll_rst=1 for exactly RST_PULSE_CYCLES cycles, then -> WAIT_LOCK (timer cleared).
// - WAIT_LOCK: pll_rst=0. locked_s=1 -> SETTLE (stable timer cleared). Else timer++; when timer
//   reaches LOCK_TIMEOUT_CYCLES: retry_count<MAX_RETRIES -> retry_count++, PLL_RST;
//   otherwise -> FAIL. locked_s=1 on the timeout cycle wins (-> SETTLE).
// - SETTLE: locked_s=1 -> stable timer++; STABLE_CYCLES consecutive -> RUN, retry_count<=0.
//   locked_s=0 -> WAIT_LOCK with timeout timer restarted; not counted as a retry.
// - RUN: core_reset_n=1, pll_ready=1. locked_s=0 -> lock_loss_count++ (sat 255), -> PLL_RST;
//   core_reset_n=0 on that same edge.
// - FAIL: pll_rst=1, core_reset_n=0, fail=1; held until reset_n or relock_req.
// - relock_req=1 in any state (incl. FAIL, PLL_RST) -> PLL_RST, timers and retry_count cleared,
//   fail cleared; lock_loss_count kept. Priority: reset_n > relock_req > locked_s events. If
//   relock_req and lock loss coincide in RUN, lock_loss_count still increments once.
// - Latency: locked_s rise in WAIT_LOCK -> pll_ready high STABLE_CYCLES+1 edges later; pll_locked
//   pin rise -> pll_ready = STABLE_CYCLES+3 edges.
// - Timers sized $clog2(max param + 1); no wrap possible. core_reset_n never high outside RUN.
// TESTING (RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=100, STABLE_CYCLES=8, MAX_RETRIES=2)
// 1 Release reset_n, pll_locked=1 from cycle 20 -> pll_rst high cycles 0..3, pll_ready and
//   core_reset_n rise exactly 11 edges after pll_locked rise, retry_count=0.
// 2 pll_locked held 0 -> three pll_rst pulses (4 cycles each, 104 apart), fail=1 at cycle 312,
//   retry_count=2, pll_rst stays 1, core_reset_n stays 0.
// 3 pll_locked rises, drops for 1 cycle 5 cycles later, re-rises -> SETTLE restarts,
//   pll_ready delayed to 11 edges after the second rise; retry_count unchanged.
// 4 In RUN drop pll_locked -> core_reset_n and pll_ready low 3 edges later, lock_loss_count=1,
//   4-cycle pll_rst pulse, pll_locked re-asserted -> RUN again.
// 5 In FAIL pulse relock_req -> fail=0, retry_count=0, pll_rst 4-cycle pulse, normal lock.
// 6 reset_n asserted mid-SETTLE and in RUN -> all outputs at reset values with no clock edge;
//   256 lock losses -> lock_loss_count holds 255.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer: pulses PLL reset, waits for lock with timeout and
// bounded retries, qualifies a stable-lock window, then releases core reset.
//
// Ports:
//   clk_74a         in  reference clock (PLL refclk domain)
//   reset_n         in  async active-low reset
//   pll_locked      in  PLL lock flag, asynchronous
//   relock_req      in  one-cycle pulse, restart the full lock sequence
//   pll_rst         out active-high PLL reset
//   core_reset_n    out active-low core reset, high only in RUN
//   pll_ready       out high only in RUN
//   fail            out high only in FAIL (retries exhausted)
//   retry_count     out timeouts since last lock or relock_req
//   lock_loss_count out lock losses seen in RUN, saturating
module pll_lock_sequencer #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 742500,
  parameter int STABLE_CYCLES       = 4096,
  parameter int MAX_RETRIES         = 3
) (
  input  logic       clk_74a,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       core_reset_n,
  output logic       pll_ready,
  output logic       fail,
  output logic [3:0] retry_count,
  output logic [7:0] lock_loss_count
);

  localparam int MAX_A =
    (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
    RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_P =
    (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
  localparam int TW = $clog2(MAX_P + 1);

  localparam logic [TW-1:0] RST_LAST =
    TW'(RST_PULSE_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST =
    TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] ST_LAST =
    TW'(STABLE_CYCLES - 1);
  localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_SETTLE,
    S_RUN,
    S_FAIL
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [TW-1:0] tmr;
  logic [TW-1:0] tmr_nxt;
  logic [3:0]    retry_nxt;
  logic [7:0]    loss_nxt;
  logic [1:0]    sync_q;
  logic          locked_s;

  assign locked_s = sync_q[1];

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], pll_locked};
    end
  end

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_PLL_RST;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    retry_nxt = retry_count;
    loss_nxt  = lock_loss_count;

    // Loss is counted even when a relock request wins the transition.
    if (state == S_RUN && !locked_s &&
        lock_loss_count != 8'hFF) begin
      loss_nxt = lock_loss_count + 8'd1;
    end

    if (relock_req) begin
      state_nxt = S_PLL_RST;
      tmr_nxt   = '0;
      retry_nxt = 4'd0;
    end else begin
      unique case (state)
        S_PLL_RST: begin
          if (tmr == RST_LAST) begin
            state_nxt = S_WAIT_LOCK;
            tmr_nxt   = '0;
          end else begin
            tmr_nxt = tmr + 1'b1;
          end
        end
        S_WAIT_LOCK: begin
          if (locked_s) begin
            state_nxt = S_SETTLE;
            tmr_nxt   = '0;
          end else if (tmr == TO_LAST) begin
            tmr_nxt = '0;
            if (retry_count < RETRY_MAX) begin
              retry_nxt = retry_count + 4'd1;
              state_nxt = S_PLL_RST;
            end else begin
              state_nxt = S_FAIL;
            end
          end else begin
            tmr_nxt = tmr + 1'b1;
          end
        end
        S_SETTLE: begin
          if (!locked_s) begin
            state_nxt = S_WAIT_LOCK;
            tmr_nxt   = '0;
          end else if (tmr == ST_LAST) begin
            state_nxt = S_RUN;
            tmr_nxt   = '0;
            retry_nxt = 4'd0;
          end else begin
            tmr_nxt = tmr + 1'b1;
          end
        end
        S_RUN: begin
          if (!locked_s) begin
            state_nxt = S_PLL_RST;
            tmr_nxt   = '0;
          end
        end
        S_FAIL: begin
          state_nxt = S_FAIL;
        end
        default: begin
          state_nxt = S_PLL_RST;
          tmr_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs decode next state so they move on the entry edge.
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      tmr             <= '0;
      retry_count     <= 4'd0;
      lock_loss_count <= 8'd0;
      pll_rst         <= 1'b1;
      core_reset_n    <= 1'b0;
      pll_ready       <= 1'b0;
      fail            <= 1'b0;
    end else begin
      tmr             <= tmr_nxt;
      retry_count     <= retry_nxt;
      lock_loss_count <= loss_nxt;
      pll_rst         <= (state_nxt == S_PLL_RST) ||
                         (state_nxt == S_FAIL);
      core_reset_n    <= (state_nxt == S_RUN);
      pll_ready       <= (state_nxt == S_RUN);
      fail            <= (state_nxt == S_FAIL);
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer with short timing parameters.
// Expected values are queued with the stimulus and popped on observation.
module tb_pll_lock_sequencer;

  logic       clk_74a = 1'b0;
  logic       reset_n = 1'b1;
  logic       pll_locked = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_rst;
  logic       core_reset_n;
  logic       pll_ready;
  logic       fail;
  logic [3:0] retry_count;
  logic [7:0] lock_loss_count;

  pll_lock_sequencer #(
    .RST_PULSE_CYCLES   (4),
    .LOCK_TIMEOUT_CYCLES(100),
    .STABLE_CYCLES      (8),
    .MAX_RETRIES        (2)
  ) dut (
    .clk_74a        (clk_74a),
    .reset_n        (reset_n),
    .pll_locked     (pll_locked),
    .relock_req     (relock_req),
    .pll_rst        (pll_rst),
    .core_reset_n   (core_reset_n),
    .pll_ready      (pll_ready),
    .fail           (fail),
    .retry_count    (retry_count),
    .lock_loss_count(lock_loss_count)
  );

  always #5 clk_74a = ~clk_74a;

  typedef struct {
    string tag;
    int    val;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  localparam int SEL_RST   = 0;
  localparam int SEL_CORE  = 1;
  localparam int SEL_READY = 2;
  localparam int SEL_FAIL  = 3;

  task automatic chk(string tag, int obs, int exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(string tag, int val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic observe(int obs);
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_underflow", obs, -1);
    end else begin
      e = sb.pop_front();
      chk(e.tag, obs, e.val);
    end
  endtask

  function automatic logic sig(int sel);
    case (sel)
      SEL_RST:   return pll_rst;
      SEL_CORE:  return core_reset_n;
      SEL_READY: return pll_ready;
      default:   return fail;
    endcase
  endfunction

  task automatic tick(int n);
    repeat (n) @(posedge clk_74a);
    #1;
  endtask

  task automatic wait_sig(int sel, logic val, int lim,
                          output int n);
    n = 0;
    while (sig(sel) !== val && n < lim) begin
      @(posedge clk_74a);
      #1;
      n++;
    end
    if (sig(sel) !== val) chk("timeout", sel, -1);
  endtask

  task automatic check_reset(string p);
    push_exp({p, "_pll_rst"}, 1);
    push_exp({p, "_core_rst_n"}, 0);
    push_exp({p, "_ready"}, 0);
    push_exp({p, "_fail"}, 0);
    push_exp({p, "_retry"}, 0);
    push_exp({p, "_loss"}, 0);
    observe(int'(pll_rst));
    observe(int'(core_reset_n));
    observe(int'(pll_ready));
    observe(int'(fail));
    observe(int'(retry_count));
    observe(int'(lock_loss_count));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int fail_at;
    int core_hi;
    int exp_loss;
    logic prev;
    int falls[$];
    int rises[$];

    // Initial async reset, no clock edge yet
    #1 reset_n = 1'b0;
    #2 check_reset("por");

    // Lock from cycle 20
    @(posedge clk_74a);
    #1 reset_n = 1'b1;
    push_exp("t1_rst_c0", 1);
    observe(int'(pll_rst));
    push_exp("t1_pulse_len", 4);
    wait_sig(SEL_RST, 1'b0, 20, n);
    observe(n);
    tick(16);
    pll_locked = 1'b1;
    push_exp("t1_lat", 11);
    wait_sig(SEL_READY, 1'b1, 40, n);
    observe(n);
    push_exp("t1_core_rst_n", 1);
    push_exp("t1_retry", 0);
    observe(int'(core_reset_n));
    observe(int'(retry_count));

    // Async reset in RUN
    reset_n = 1'b0;
    pll_locked = 1'b0;
    #2 check_reset("run_rst");

    // Never locks: retries then FAIL
    @(posedge clk_74a);
    #1 reset_n = 1'b1;
    push_exp("t2_nfall", 3);
    push_exp("t2_fall0", 4);
    push_exp("t2_fall1", 108);
    push_exp("t2_fall2", 212);
    push_exp("t2_nrise", 3);
    push_exp("t2_rise0", 104);
    push_exp("t2_rise1", 208);
    push_exp("t2_rise2", 312);
    push_exp("t2_fail_at", 312);
    push_exp("t2_core_hi", 0);
    push_exp("t2_retry", 2);
    push_exp("t2_pll_rst", 1);
    push_exp("t2_fail", 1);
    prev = pll_rst;
    fail_at = 0;
    core_hi = 0;
    for (int e = 1; e <= 340; e++) begin
      @(posedge clk_74a);
      #1;
      if (prev && !pll_rst) falls.push_back(e);
      if (!prev && pll_rst) rises.push_back(e);
      if (fail && fail_at == 0) fail_at = e;
      if (core_reset_n) core_hi++;
      prev = pll_rst;
    end
    observe(falls.size());
    for (int i = 0; i < 3; i++)
      observe(i < falls.size() ? falls[i] : -1);
    observe(rises.size());
    for (int i = 0; i < 3; i++)
      observe(i < rises.size() ? rises[i] : -1);
    observe(fail_at);
    observe(core_hi);
    observe(int'(retry_count));
    observe(int'(pll_rst));
    observe(int'(fail));

    // relock_req out of FAIL
    relock_req = 1'b1;
    tick(1);
    relock_req = 1'b0;
    push_exp("t5_fail", 0);
    push_exp("t5_retry", 0);
    push_exp("t5_pll_rst", 1);
    observe(int'(fail));
    observe(int'(retry_count));
    observe(int'(pll_rst));
    push_exp("t5_pulse", 4);
    wait_sig(SEL_RST, 1'b0, 20, n);
    observe(n);
    pll_locked = 1'b1;
    push_exp("t5_lat", 11);
    wait_sig(SEL_READY, 1'b1, 40, n);
    observe(n);

    // Lock loss in RUN
    pll_locked = 1'b0;
    push_exp("t4_core_lat", 3);
    wait_sig(SEL_CORE, 1'b0, 20, n);
    observe(n);
    push_exp("t4_ready", 0);
    push_exp("t4_loss", 1);
    push_exp("t4_pll_rst", 1);
    observe(int'(pll_ready));
    observe(int'(lock_loss_count));
    observe(int'(pll_rst));
    push_exp("t4_pulse", 4);
    wait_sig(SEL_RST, 1'b0, 20, n);
    observe(n);
    pll_locked = 1'b1;
    push_exp("t4_relat", 11);
    wait_sig(SEL_READY, 1'b1, 40, n);
    observe(n);

    // Glitch during SETTLE restarts the window
    relock_req = 1'b1;
    pll_locked = 1'b0;
    tick(1);
    relock_req = 1'b0;
    push_exp("t3_loss_kept", 1);
    observe(int'(lock_loss_count));
    push_exp("t3_pulse", 4);
    wait_sig(SEL_RST, 1'b0, 20, n);
    observe(n);
    tick(10);
    pll_locked = 1'b1;
    tick(5);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    push_exp("t3_lat", 11);
    wait_sig(SEL_READY, 1'b1, 40, n);
    observe(n);
    push_exp("t3_retry", 0);
    observe(int'(retry_count));

    // relock_req coincides with lock loss in RUN
    pll_locked = 1'b0;
    tick(2);
    relock_req = 1'b1;
    tick(1);
    relock_req = 1'b0;
    push_exp("co_loss", 2);
    push_exp("co_pll_rst", 1);
    push_exp("co_core_rst_n", 0);
    observe(int'(lock_loss_count));
    observe(int'(pll_rst));
    observe(int'(core_reset_n));
    push_exp("co_pulse", 4);
    wait_sig(SEL_RST, 1'b0, 20, n);
    observe(n);
    pll_locked = 1'b1;
    push_exp("co_lat", 11);
    wait_sig(SEL_READY, 1'b1, 40, n);
    observe(n);

    // Async reset in RUN clears loss counter
    reset_n = 1'b0;
    #2 check_reset("run_rst2");

    // Async reset mid-SETTLE
    @(posedge clk_74a);
    #1 reset_n = 1'b1;
    tick(8);
    push_exp("st_pll_rst", 0);
    push_exp("st_ready", 0);
    observe(int'(pll_rst));
    observe(int'(pll_ready));
    reset_n = 1'b0;
    #2 check_reset("settle_rst");

    // 256 lock losses saturate at 255
    @(posedge clk_74a);
    #1 reset_n = 1'b1;
    wait_sig(SEL_READY, 1'b1, 40, n);
    exp_loss = 0;
    for (int i = 0; i < 256; i++) begin
      pll_locked = 1'b0;
      wait_sig(SEL_CORE, 1'b0, 10, n);
      exp_loss = (exp_loss == 255) ? 255 : exp_loss + 1;
      push_exp("sat_loss", exp_loss);
      observe(int'(lock_loss_count));
      wait_sig(SEL_RST, 1'b0, 10, n);
      pll_locked = 1'b1;
      wait_sig(SEL_READY, 1'b1, 20, n);
    end
    push_exp("sat_final", 255);
    observe(int'(lock_loss_count));

    push_exp("sb_drained", 0);
    observe(sb.size() - 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
